pipeline_control: RTL and testbench
===================================

# pipeline_control

Pipelined main control unit for the five-stage datapath. It decodes the ID-stage opcode into the writeback, memory-access and calculation control groups. It carries each group down ID/EX, EX/MEM and MEM/WB so every stage sees the controls belonging to its own instruction. It also inserts bubbles for load-use hazards and for taken-branch flushes.

## Interface
- OPCODE_W, 6, opcode width; opcodes wider than 6 bits are zero-extended in the decode compare.
- REG_ADDR_W, 5, register specifier width for hazard compare.
- clk  input  1  rising-edge clock.
- resetN  input  1  asynchronous, active-low reset.
- opCode  input  OPCODE_W  ID-stage opcode.
- idValid  input  1  ID stage holds a real instruction; 0 decodes as bubble.
- idRs, idRt  input  REG_ADDR_W  ID-stage source registers.
- idRtDst  input  REG_ADDR_W  ID-stage rt captured into ID/EX for hazard compare.
- branchTaken  input  1  MEM-stage branch resolved taken; flush request.
- stall  output  1  hold PC and IF/ID this cycle (combinational).
- exControl  output  4  {regDst, aluOp1, aluOp0, aluSrc}, EX stage.
- memControl  output  3  {branch, memRead, memWrite}, MEM stage.
- wbControl  output  2  {regWrite, memToReg}, WB stage.
- exIllegal  output  1  EX-stage instruction had an undefined opcode.

## Operation
- Decode, as {wb | mem | ex}; no X outputs:
  - 000000 R-format: 10 | 000 | 1100.
  - 000001 LW: 11 | 010 | 0001.
  - 000010 SW: 00 | 001 | 0001.
  - 000011 BEQ: 00 | 100 | 0010.
  - 000100 ADDI: 10 | 000 | 0001.
  - Any other opcode: all zero, illegal=1.
- Bubble: all control bits 0 and illegal=0. Produced when idValid=0, stall=1 or branchTaken=1.
- ID/EX holds {wb, mem, ex, illegal, idRtDst}.
- EX/MEM holds {wb, mem}.
- MEM/WB holds {wb}.
- Load-use hazard: stall=1 when all of the following hold:
  - idValid=1;
  - ID/EX memRead=1;
  - ID/EX rt is nonzero;
  - ID/EX rt equals idRs or idRt.
- On stall, ID/EX loads a bubble. EX/MEM and MEM/WB advance normally.
- Flush: branchTaken=1 loads a bubble into both ID/EX and EX/MEM at the next edge. MEM/WB advances normally, so the branch itself completes.
- Simultaneous flush and hazard: flush wins and stall is forced to 0.
- Reset: all pipeline registers clear to bubble immediately (asynchronous). While resetN=0, all outputs are 0 and stall=0.
- Reset mid-operation discards all in-flight controls. No partial writes are issued after resetN rises.

## Timing
- Opcode presented before edge N appears at the outputs as follows:
  - exControl and exIllegal after edge N;
  - memControl after edge N+1;
  - wbControl after edge N+2.
- stall is combinational from opCode/idRs/idRt/idValid/branchTaken and registered ID/EX state. It is valid in the same cycle; no registered delay.
- A load followed immediately by a dependent instruction produces exactly one stall cycle. The second compare sees a bubble in ID/EX, so stall drops.
- branchTaken is sampled at the rising edge. A single-cycle pulse produces exactly two bubbles (ID/EX and EX/MEM).
- Single clock domain; no multicycle paths.

## Configuration
- HAZARD_STALL_EN defined: load-use detection as above; ID/EX carries rt.
- Undefined: stall is tied 0, ID/EX omits the rt field, and no hazard bubbles are inserted. Software scheduling is responsible for load-use spacing. Flush behaviour is unchanged.

## Test plan
- Reset: with resetN=0, drive opCode=000001 and idValid=1. Required: exControl=0000, memControl=000, wbControl=00, stall=0. After release plus 1 edge, exControl=0001.
- R-format flow: opCode=000000 at edge 1. Required: exControl=1100 after edge 1, memControl=000 after edge 2, wbControl=10 after edge 3.
- Load-use: LW (idRtDst=5), then ADD with idRs=5. Required:
  - stall=1 for one cycle;
  - ID/EX shows a bubble (exControl=0000) after that edge;
  - the ADD reaches EX one cycle later with exControl=1100.
- No hazard cases: LW to r0 followed by a reader of r0 gives stall=0. LW rt=5 followed by a reader of r6 gives stall=0.
- Flush: BEQ then ADD then SW in flight, with branchTaken pulsed 1 cycle. Required:
  - next-cycle exControl=0000 and memControl=000;
  - the BEQ's wbControl=00 still retires.
- Same-cycle flush and hazard: assert branchTaken during a load-use hazard. Required: stall=0 and two bubbles.
- Illegal opcode: opCode=111111. Required: exIllegal=1 and all control groups 0 through every stage.

Source files
------------

// File: rtl/pipeline_control.sv
// pipeline_control: main control decode plus ID/EX, EX/MEM and MEM/WB control
// registers. Inserts bubbles for load-use hazards and taken-branch flushes.
// Optional feature macro: HAZARD_STALL_EN. When it is defined, load-use
// detection is enabled and ID/EX carries rt. When it is not defined, stall is
// tied to 0.
module pipeline_control #(
    parameter int OPCODE_W   = 6,
    parameter int REG_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  resetN,
    input  logic [OPCODE_W-1:0]   opCode,
    input  logic                  idValid,
    input  logic [REG_ADDR_W-1:0] idRs,
    input  logic [REG_ADDR_W-1:0] idRt,
    input  logic [REG_ADDR_W-1:0] idRtDst,
    input  logic                  branchTaken,
    output logic                  stall,
    output logic [3:0]            exControl,
    output logic [2:0]            memControl,
    output logic [1:0]            wbControl,
    output logic                  exIllegal
);

    typedef struct packed {
        logic [1:0]            wb;
        logic [2:0]            mem;
        logic [3:0]            ex;
        logic                  illegal;
`ifdef HAZARD_STALL_EN
        logic [REG_ADDR_W-1:0] rt;
`endif
    } idex_t;

    typedef struct packed {
        logic [1:0] wb;
        logic [2:0] mem;
    } exmem_t;

    idex_t      idex_q, idex_d;
    exmem_t     exmem_q, exmem_d;
    logic [1:0] memwb_q;

    logic [1:0] dec_wb;
    logic [2:0] dec_mem;
    logic [3:0] dec_ex;
    logic       dec_ill;
    logic [31:0] op_ext;
    logic       bubble;

    // Compare against a zero-extended opcode so that any OPCODE_W decodes the same codes.
    assign op_ext = 32'(opCode);

    // Opcode decode into {wb | mem | ex}. Undefined opcodes give all-zero controls and flag illegal.
    always_comb begin
        dec_wb  = 2'b00;
        dec_mem = 3'b000;
        dec_ex  = 4'b0000;
        dec_ill = 1'b0;
        case (op_ext)
            32'd0: begin dec_wb = 2'b10; dec_mem = 3'b000; dec_ex = 4'b1100; end // R-format
            32'd1: begin dec_wb = 2'b11; dec_mem = 3'b010; dec_ex = 4'b0001; end // LW
            32'd2: begin dec_wb = 2'b00; dec_mem = 3'b001; dec_ex = 4'b0001; end // SW
            32'd3: begin dec_wb = 2'b00; dec_mem = 3'b100; dec_ex = 4'b0010; end // BEQ
            32'd4: begin dec_wb = 2'b10; dec_mem = 3'b000; dec_ex = 4'b0001; end // ADDI
            default: dec_ill = 1'b1;
        endcase
    end

`ifdef HAZARD_STALL_EN
    logic hazard;
    // Load-use hazard: the load in EX writes a nonzero rt that the ID instruction reads.
    assign hazard = idValid && idex_q.mem[1] && (idex_q.rt != '0) &&
                    ((idex_q.rt == idRs) || (idex_q.rt == idRt));
    // A flush discards the dependent instruction anyway, so it overrides the stall.
    assign stall  = hazard && !branchTaken;
`else
    logic unused_hazard_inputs;
    // Without hazard detection, software has to space loads and their users.
    assign stall = 1'b0;
    assign unused_hazard_inputs = ^{idRs, idRt, idRtDst};
`endif

    assign bubble = !idValid || stall || branchTaken;

    // Next ID/EX contents: the decoded controls, or a bubble.
    always_comb begin
        idex_d = '0;
        if (!bubble) begin
            idex_d.wb      = dec_wb;
            idex_d.mem     = dec_mem;
            idex_d.ex      = dec_ex;
            idex_d.illegal = dec_ill;
`ifdef HAZARD_STALL_EN
            idex_d.rt      = idRtDst;
`endif
        end
    end

    // Next EX/MEM contents: a flush also kills the instruction that is leaving EX.
    always_comb begin
        exmem_d = '0;
        if (!branchTaken) begin
            exmem_d.wb  = idex_q.wb;
            exmem_d.mem = idex_q.mem;
        end
    end

    // Pipeline control registers. Reset clears them to bubbles, so no in-flight write survives a reset.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            idex_q  <= '0;
            exmem_q <= '0;
            memwb_q <= '0;
        end else begin
            idex_q  <= idex_d;
            exmem_q <= exmem_d;
            memwb_q <= exmem_q.wb;
        end
    end

    assign exControl  = idex_q.ex;
    assign exIllegal  = idex_q.illegal;
    assign memControl = exmem_q.mem;
    assign wbControl  = memwb_q;

endmodule

// File: tb/tb_pipeline_control.sv
// tb_pipeline_control: directed vectors with hand-computed expected control values.
module tb_pipeline_control;

    logic       clk;
    logic       resetN;
    logic [5:0] opCode;
    logic       idValid;
    logic [4:0] idRs, idRt, idRtDst;
    logic       branchTaken;
    logic       stall;
    logic [3:0] exControl;
    logic [2:0] memControl;
    logic [1:0] wbControl;
    logic       exIllegal;

    int n_cmp = 0;
    int n_err = 0;

`ifdef HAZARD_STALL_EN
    localparam logic HZ = 1'b1;
`else
    localparam logic HZ = 1'b0;
`endif

    pipeline_control #(.OPCODE_W(6), .REG_ADDR_W(5)) dut (
        .clk(clk), .resetN(resetN), .opCode(opCode), .idValid(idValid),
        .idRs(idRs), .idRt(idRt), .idRtDst(idRtDst), .branchTaken(branchTaken),
        .stall(stall), .exControl(exControl), .memControl(memControl),
        .wbControl(wbControl), .exIllegal(exIllegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drv(input logic [5:0] op, input logic v, input logic [4:0] rs,
                       input logic [4:0] rt, input logic [4:0] rtd, input logic bt);
        opCode = op; idValid = v; idRs = rs; idRt = rt; idRtDst = rtd; branchTaken = bt;
    endtask

    logic [5:0] t_op  [6] = '{6'd0, 6'd1, 6'd2, 6'd3, 6'd4, 6'd63};
    logic [3:0] t_ex  [6] = '{4'b1100, 4'b0001, 4'b0001, 4'b0010, 4'b0001, 4'b0000};
    logic [2:0] t_mem [6] = '{3'b000, 3'b010, 3'b001, 3'b100, 3'b000, 3'b000};
    logic [1:0] t_wb  [6] = '{2'b10, 2'b11, 2'b00, 2'b00, 2'b10, 2'b00};
    logic       t_ill [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

    initial begin
        // Reset holds every output low even with a valid LW presented
        resetN = 1'b0;
        drv(6'd1, 1'b1, 5'd0, 5'd0, 5'd0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ex", 8'(exControl), 8'b0000);
        chk("rst_mem", 8'(memControl), 8'b000);
        chk("rst_wb", 8'(wbControl), 8'b00);
        chk("rst_stall", 8'(stall), 8'b0);
        chk("rst_ill", 8'(exIllegal), 8'b0);
        resetN = 1'b1;
        step();
        chk("rel_ex", 8'(exControl), 8'b0001);
        drv(6'd0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
        step();
        chk("rel_mem", 8'(memControl), 8'b010);
        chk("rel_ex_idle", 8'(exControl), 8'b0000);
        step();
        chk("rel_wb", 8'(wbControl), 8'b11);
        step();

        // Decode table streamed back to back: each stage shows its own instruction
        for (int i = 0; i < 8; i++) begin
            if (i < 6) drv(t_op[i], 1'b1, 5'd0, 5'd0, 5'd0, 1'b0);
            else       drv(6'd0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
            step();
            if (i < 6) begin
                chk($sformatf("dec_ex%0d", i), 8'(exControl), 8'(t_ex[i]));
                chk($sformatf("dec_ill%0d", i), 8'(exIllegal), 8'(t_ill[i]));
            end
            if (i >= 1 && i <= 6) chk($sformatf("dec_mem%0d", i - 1), 8'(memControl), 8'(t_mem[i - 1]));
            if (i >= 2) chk($sformatf("dec_wb%0d", i - 2), 8'(wbControl), 8'(t_wb[i - 2]));
        end
        step();

        // Load-use: LW r5 then ADD reading r5
        drv(6'd1, 1'b1, 5'd0, 5'd0, 5'd5, 1'b0);
        step();
        chk("lu_lw_ex", 8'(exControl), 8'b0001);
        drv(6'd0, 1'b1, 5'd5, 5'd7, 5'd0, 1'b0);
        #1;
        chk("lu_stall", 8'(stall), 8'(HZ));
        step();
`ifdef HAZARD_STALL_EN
        chk("lu_bubble_ex", 8'(exControl), 8'b0000);
        chk("lu_stall_drop", 8'(stall), 8'b0);
        step();
        chk("lu_add_ex", 8'(exControl), 8'b1100);
`else
        chk("lu_add_ex", 8'(exControl), 8'b1100);
`endif
        drv(6'd0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
        repeat (3) step();

        // No hazard: LW to r0, reader of r0; LW to r5, reader of r6
        drv(6'd1, 1'b1, 5'd0, 5'd0, 5'd0, 1'b0);
        step();
        drv(6'd0, 1'b1, 5'd0, 5'd0, 5'd0, 1'b0);
        #1;
        chk("nh_r0_stall", 8'(stall), 8'b0);
        step();
        drv(6'd1, 1'b1, 5'd0, 5'd0, 5'd5, 1'b0);
        step();
        drv(6'd0, 1'b1, 5'd6, 5'd6, 5'd0, 1'b0);
        #1;
        chk("nh_r6_stall", 8'(stall), 8'b0);
        step();
        chk("nh_r6_ex", 8'(exControl), 8'b1100);
        drv(6'd0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
        repeat (3) step();

        // Flush: LW, BEQ, ADDI in flight, SW in ID, branch resolves in MEM
        drv(6'd1, 1'b1, 5'd0, 5'd0, 5'd0, 1'b0);
        step();
        drv(6'd3, 1'b1, 5'd0, 5'd0, 5'd0, 1'b0);
        step();
        drv(6'd4, 1'b1, 5'd0, 5'd0, 5'd0, 1'b0);
        step();
        drv(6'd2, 1'b1, 5'd0, 5'd0, 5'd0, 1'b1);
        #1;
        chk("fl_pre_mem", 8'(memControl), 8'b100);
        chk("fl_pre_wb", 8'(wbControl), 8'b11);
        step();
        chk("fl_ex", 8'(exControl), 8'b0000);
        chk("fl_mem", 8'(memControl), 8'b000);
        chk("fl_beq_wb", 8'(wbControl), 8'b00);
        drv(6'd0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
        step();
        chk("fl_post_mem", 8'(memControl), 8'b000);
        chk("fl_post_wb", 8'(wbControl), 8'b00);
        repeat (2) step();

        // Flush and load-use hazard in the same cycle: flush wins
        drv(6'd1, 1'b1, 5'd0, 5'd0, 5'd5, 1'b0);
        step();
        drv(6'd0, 1'b1, 5'd5, 5'd0, 5'd0, 1'b1);
        #1;
        chk("fh_stall", 8'(stall), 8'b0);
        step();
        chk("fh_ex", 8'(exControl), 8'b0000);
        chk("fh_mem", 8'(memControl), 8'b000);
        drv(6'd0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
        step();
        chk("fh_wb", 8'(wbControl), 8'b00);
        step();

        // Illegal opcode travels as all-zero controls
        drv(6'd63, 1'b1, 5'd0, 5'd0, 5'd0, 1'b0);
        step();
        chk("il_flag", 8'(exIllegal), 8'b1);
        chk("il_ex", 8'(exControl), 8'b0000);
        drv(6'd5, 1'b1, 5'd0, 5'd0, 5'd0, 1'b0);
        step();
        chk("il5_flag", 8'(exIllegal), 8'b1);
        chk("il_mem", 8'(memControl), 8'b000);
        drv(6'd0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
        step();
        chk("il_wb", 8'(wbControl), 8'b00);
        chk("il_clear", 8'(exIllegal), 8'b0);

        // Asynchronous reset in mid-operation discards in-flight controls
        drv(6'd1, 1'b1, 5'd0, 5'd0, 5'd0, 1'b0);
        step();
        step();
        chk("mr_pre_mem", 8'(memControl), 8'b010);
        #2 resetN = 1'b0;
        #1;
        chk("mr_ex", 8'(exControl), 8'b0000);
        chk("mr_mem", 8'(memControl), 8'b000);
        step();
        chk("mr_wb", 8'(wbControl), 8'b00);
        resetN = 1'b1;
        drv(6'd0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
        step();
        chk("mr_post_wb", 8'(wbControl), 8'b00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
